tnoc_vc_flit_buffer: RTL and testbench
======================================

# tnoc_vc_flit_buffer

Per-virtual-channel flit FIFO that sits directly downstream of the VC demultiplexer in the router input port. It receives one VC's flit stream through a valid/ready handshake and stores it in a DEPTH-entry circular buffer. It presents the head flit to the downstream route/arbitration stage. It returns a registered `vc_available` indication upstream so senders stop issuing flits to this VC before it fills.

## Interface
Parameters:
- FLIT_WIDTH, 64: width of one flit (opaque payload; not decoded here).
- DEPTH, 4: number of flit entries; must be a power of two, 2..64.
- THRESHOLD, 2: minimum free entries for `o_vc_available` to be high; 1..DEPTH.

Ports:
- i_clk  in  1  clock; all state updates on its rising edge.
- i_rst_n  in  1  reset; synchronous, active-low.
- i_valid  in  1  upstream flit valid for this VC.
- o_ready  out  1  buffer can accept a flit this cycle.
- i_flit  in  FLIT_WIDTH  upstream flit.
- o_vc_available  out  1  registered; free entries ≥ THRESHOLD.
- o_valid  out  1  head flit valid.
- i_ready  in  1  downstream accepts head flit.
- o_flit  out  FLIT_WIDTH  head flit.
- o_count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.

## Operation
- Storage is a DEPTH-entry array with write pointer, read pointer and occupancy counter. Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0. The counter is $clog2(DEPTH)+1 bits.
- Push occurs when `i_valid && o_ready`. The flit is written at the write pointer, and the pointer increments.
- Pop occurs when `o_valid && i_ready`. The read pointer increments.
- `o_ready = (count != DEPTH)`. The buffer accepts input even when `o_vc_available` is low. Credit policy is the sender's responsibility.
- `o_valid = (count != 0)`. `o_flit = mem[rd_ptr]` is combinational from storage. Array contents are not reset.
- Count update:
  - push only: +1.
  - pop only: −1.
  - push and pop together: unchanged, including when full. When full, `o_ready` is 0, so no push can occur.
- The next value of `o_vc_available` is `(DEPTH − count_next) ≥ THRESHOLD`. It is registered.
- Reset (`i_rst_n` low at a clock edge) clears the pointers and count and sets `o_vc_available` = 1. This applies mid-operation too: any stored flits are discarded.
- Reset values:
  - `o_ready` = 1.
  - `o_valid` = 0.
  - `o_vc_available` = 1.
  - `o_count` = 0.
  - `o_flit` is don't-care.

## Timing
- Write-to-read latency is 1 cycle: a flit pushed at edge N is visible on `o_valid`/`o_flit` after edge N.
- Throughput is one push and one pop per cycle, sustained.
- `o_vc_available` reflects the post-edge occupancy. It changes in the same cycle as `o_count`, with no extra lag.
- `o_valid` and `o_flit` must not depend combinationally on `i_ready`. `o_ready` must not depend on `i_valid`.
- Flit order is strictly FIFO; no flit is dropped or duplicated.

## Configuration
- `TNOC_VC_FLIT_BUFFER_BYPASS_EN` defined:
  - When count = 0, `o_valid = i_valid` and `o_flit = i_flit` combinationally.
  - If `i_ready` is also high, the flit passes with 0-cycle latency. It is neither written nor counted, and the pointers are unchanged.
  - If `i_ready` is low, the flit is pushed normally.
- Not defined:
  - No combinational input-to-output path.
  - Minimum latency is 1 cycle.
- All other behaviour is identical in both builds.

## Test plan
Parameters DEPTH=4 and THRESHOLD=2 unless noted.
- Reset: assert `i_rst_n`=0 for 2 cycles with `i_valid`=1 → `o_valid`=0, `o_ready`=1, `o_vc_available`=1, `o_count`=0.
- Fill/drain: push A,B,C,D with `i_ready`=0 → `o_count` goes 1,2,3,4; `o_vc_available` falls after the 3rd push; `o_ready`=0 after the 4th. Then pop 4 → output A,B,C,D in order, and `o_vc_available` rises after the 2nd pop.
- Wrap-around: stream 10 flits 0x0..0x9 with `i_ready` toggling 1,0,1,0 → all 10 arrive in order; pointers wrap twice; `o_count` never exceeds 4.
- Simultaneous push and pop when full: count=4, `i_valid`=1, `i_ready`=1 → pop only (`o_ready`=0); count=3 next cycle. Then push and pop together → count stays 3.
- Reset mid-operation: count=3, assert reset → next cycle count=0, `o_valid`=0; the next pushed flit 0x55 appears as head.
- Bypass (`TNOC_VC_FLIT_BUFFER_BYPASS_EN`): empty buffer, `i_valid`=`i_ready`=1, `i_flit`=0xAB → `o_valid`=1 and `o_flit`=0xAB in the same cycle; `o_count` stays 0. Without the macro → `o_valid`=0 that cycle and 0xAB appears next cycle.

Source files
------------

// File: rtl/tnoc_vc_flit_buffer.sv
// Per-VC flit FIFO with registered upstream availability flag.
// Optional build macro TNOC_VC_FLIT_BUFFER_BYPASS_EN enables an empty-buffer cut-through path.
module tnoc_vc_flit_buffer #(
  parameter int FLIT_WIDTH = 64,
  parameter int DEPTH      = 4,
  parameter int THRESHOLD  = 2
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_valid,
  output logic                       o_ready,
  input  logic [FLIT_WIDTH-1:0]      i_flit,
  output logic                       o_vc_available,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [FLIT_WIDTH-1:0]      o_flit,
  output logic [$clog2(DEPTH):0]     o_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] THR_C   = CW'(THRESHOLD);

  logic [FLIT_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         count, count_next, free_next;
  logic                  vc_available;
  logic                  empty, full, push, pop, pass;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH_C);
  assign o_ready = !full;

`ifdef TNOC_VC_FLIT_BUFFER_BYPASS_EN
  // An empty buffer forwards the input directly; a consumed cut-through flit is never stored.
  assign o_valid = empty ? i_valid : 1'b1;
  assign o_flit  = empty ? i_flit  : mem[rd_ptr];
  assign pass    = empty && i_valid && i_ready;
`else
  assign o_valid = !empty;
  assign o_flit  = mem[rd_ptr];
  assign pass    = 1'b0;
`endif

  assign push = i_valid && !full && !pass;
  assign pop  = !empty && i_ready;

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  assign free_next = DEPTH_C - count_next;

  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= i_flit;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      vc_available <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count        <= count_next;
      vc_available <= (free_next >= THR_C);
    end
  end

  assign o_vc_available = vc_available;
  assign o_count        = count;
endmodule

// File: tb/tb_tnoc_vc_flit_buffer.sv
// Randomized + directed bench for tnoc_vc_flit_buffer against a queue-based model.
module tb_tnoc_vc_flit_buffer;
  localparam int FW    = 64;
  localparam int DEPTH = 4;
  localparam int THR   = 2;
  localparam int CW    = $clog2(DEPTH) + 1;
`ifdef TNOC_VC_FLIT_BUFFER_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          gclk = 1'b0;
  logic          rst_n, valid_in, ready_in, ready_out, valid_out, avail;
  logic [FW-1:0] flit_in, flit_out;
  logic [CW-1:0] count;

  logic [FW-1:0] q[$];
  int            n_chk = 0;
  int            n_err = 0;

  always #5 gclk = ~gclk;

  tnoc_vc_flit_buffer #(.FLIT_WIDTH(FW), .DEPTH(DEPTH), .THRESHOLD(THR)) dut (
    .i_clk          (gclk),
    .i_rst_n        (rst_n),
    .i_valid        (valid_in),
    .o_ready        (ready_out),
    .i_flit         (flit_in),
    .o_vc_available (avail),
    .o_valid        (valid_out),
    .i_ready        (ready_in),
    .o_flit         (flit_out),
    .o_count        (count)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle, check outputs mid-cycle against the model, then advance the model at the edge.
  task automatic step(input logic r, input logic v, input logic rd, input logic [FW-1:0] f);
    int  sz;
    bit  bp, pass, pop, push;
    rst_n = r; valid_in = v; ready_in = rd; flit_in = f;
    @(negedge gclk);
    sz = q.size();
    bp = BYP && (sz == 0);
    chk("count", 64'(count), 64'(sz));
    chk("ready", 64'(ready_out), 64'(sz != DEPTH));
    chk("avail", 64'(avail), 64'((DEPTH - sz) >= THR));
    chk("valid", 64'(valid_out), bp ? 64'(v) : 64'(sz != 0));
    if (sz != 0) chk("flit", flit_out, q[0]);
    else if (bp && v) chk("bypass_flit", flit_out, f);
    @(posedge gclk);
    if (!r) q.delete();
    else begin
      pass = bp && v && rd;
      pop  = (sz != 0) && rd;
      push = v && (sz != DEPTH) && !pass;
      if (pop)  void'(q.pop_front());
      if (push) q.push_back(f);
    end
    #1;
  endtask

  initial begin
    int k;
    rst_n = 1'b0; valid_in = 1'b1; ready_in = 1'b0; flit_in = '0;
    @(posedge gclk); #1;
    // reset held with valid high
    step(0, 1, 0, 64'h11);
    step(0, 1, 0, 64'h22);
    // fill A..D, attempt overflow, drain
    step(1, 1, 0, 64'hA);
    step(1, 1, 0, 64'hB);
    step(1, 1, 0, 64'hC);
    step(1, 1, 0, 64'hD);
    step(1, 1, 0, 64'hE);
    for (int i = 0; i < 5; i++) step(1, 0, 1, '0);
    // wrap-around stream with toggling ready
    k = 0;
    for (int c = 0; c < 40 && k < 10; c++) begin
      if (q.size() != DEPTH) begin
        step(1, 1, (c % 2) == 0, 64'(k));
        k++;
      end else step(1, 1, (c % 2) == 0, 64'(k));
    end
    for (int i = 0; i < 6; i++) step(1, 0, 1, '0);
    // full with simultaneous push/pop, then steady push/pop at 3
    for (int i = 0; i < 4; i++) step(1, 1, 0, 64'h100 + 64'(i));
    step(1, 1, 1, 64'h200);
    step(1, 1, 1, 64'h201);
    step(1, 1, 1, 64'h202);
    // reset mid-operation, then first flit becomes head
    step(0, 0, 0, '0);
    step(1, 1, 0, 64'h55);
    step(1, 0, 0, '0);
    step(1, 0, 1, '0);
    // empty buffer, valid and ready together
    step(1, 1, 1, 64'hAB);
    step(1, 0, 1, '0);
    // random traffic
    for (int i = 0; i < 3000; i++)
      step(($urandom_range(0, 199) != 0), ($urandom_range(0, 2) != 0),
           ($urandom_range(0, 2) != 0), {$urandom, $urandom});
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
